// File: rtl/period_meter.sv
// Measures the spacing between rising edges of i_sig_in as a count of i_count_en cycles.
// A period runs from one rise (included) to the next (excluded); the counter saturates at all ones.
module period_meter #(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_count_en,
    input  logic             i_sig_in,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_period,
    output logic             o_valid,
    output logic             o_overflow,
    output logic             o_busy
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_overflow;
    logic             r_sig_prev;

    logic             w_rise;
    logic             w_cnt_max;
    logic [WIDTH-1:0] w_cnt_start;

    assign w_rise      = i_sig_in & ~r_sig_prev;
    assign w_cnt_max   = (r_cnt == {WIDTH{1'b1}});
    // The rise cycle itself belongs to the new period, so it is credited here.
    assign w_cnt_start = {{(WIDTH-1){1'b0}}, i_count_en};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_sig_prev <= 1'b1;
        end else begin
            r_sig_prev <= i_sig_in;
            r_valid    <= 1'b0;
            if (i_clear) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_period   <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= w_cnt_start;
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise) begin
                            r_period <= r_cnt;
                            r_valid  <= 1'b1;
                            r_cnt    <= w_cnt_start;
                        end else if (i_count_en) begin
                            if (w_cnt_max) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_period   = r_period;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state == S_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus random traffic, checked every cycle
// against a reference that counts enabled cycles between rises with plain integers.
module tb_period_meter;

    localparam int WIDTH = 9;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             count_en;
    logic             sig_in;
    logic             clear;
    logic [WIDTH-1:0] o_period;
    logic             o_valid;
    logic             o_overflow;
    logic             o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    bit m_prev;
    bit m_meas;
    int m_sum;
    int m_period;
    bit m_valid;
    bit m_ovf;
    int last_period;

    period_meter #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_count_en (count_en),
        .i_sig_in   (sig_in),
        .i_clear    (clear),
        .o_period   (o_period),
        .o_valid    (o_valid),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = 1'b1;
        m_meas   = 1'b0;
        m_sum    = 0;
        m_period = 0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Period = number of enabled cycles from the starting rise (included) to the ending rise (excluded).
    task automatic model_cycle(input bit sig, input bit en, input bit clr);
        bit rise;
        rise    = sig && !m_prev;
        m_prev  = sig;
        m_valid = 1'b0;
        if (clr) begin
            m_meas   = 1'b0;
            m_sum    = 0;
            m_period = 0;
            m_ovf    = 1'b0;
        end else if (rise) begin
            if (m_meas) begin
                m_period = (m_sum > MAXV) ? MAXV : m_sum;
                m_valid  = 1'b1;
            end
            m_meas = 1'b1;
            m_sum  = en ? 1 : 0;
        end else if (m_meas && en) begin
            m_sum++;
            if (m_sum > MAXV) m_ovf = 1'b1;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".period"},   32'(o_period),   32'(m_period));
        chk({ctx, ".valid"},    32'(o_valid),    32'(m_valid));
        chk({ctx, ".overflow"}, 32'(o_overflow), 32'(m_ovf));
        chk({ctx, ".busy"},     32'(o_busy),     32'(m_meas));
    endtask

    task automatic step(input string ctx, input bit sig, input bit en, input bit clr);
        sig_in   = sig;
        count_en = en;
        clear    = clr;
        @(posedge clk);
        #1;
        model_cycle(sig, en, clr);
        if (o_valid) last_period = int'(o_period);
        check_all(ctx);
    endtask

    task automatic async_reset_check(input string ctx);
        #1 rst = 1'b1;
        #1;
        chk({ctx, ".period0"},   32'(o_period),   32'd0);
        chk({ctx, ".valid0"},    32'(o_valid),    32'd0);
        chk({ctx, ".overflow0"}, 32'(o_overflow), 32'd0);
        chk({ctx, ".busy0"},     32'(o_busy),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; count_en = 1'b0; sig_in = 1'b0; clear = 1'b0;
        last_period = -1;
        model_reset();
        #12;
        chk("reset.period",   32'(o_period),   32'd0);
        chk("reset.valid",    32'(o_valid),    32'd0);
        chk("reset.overflow", 32'(o_overflow), 32'd0);
        chk("reset.busy",     32'(o_busy),     32'd0);
        rst = 1'b0;

        // basic: rises at 5, 15, 25, high for 3 cycles
        for (int c = 0; c < 30; c++)
            step("basic", (c >= 5) && (((c - 5) % 10) < 3), 1'b1, 1'b0);
        chk("basic.last_period", 32'(last_period), 32'd10);

        // prescaled: enable every 4th cycle, rises 40 apart
        step("pre_clr", 1'b0, 1'b0, 1'b1);
        last_period = -1;
        for (int c = 0; c < 130; c++)
            step("prescale", (c % 40) < 3, (c % 4) == 0, 1'b0);
        chk("prescale.last_period", 32'(last_period), 32'd10);
        chk("prescale.overflow",    32'(o_overflow),  32'd0);

        // saturation: 600-cycle period then 20-cycle period
        step("sat_clr", 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 602; c++)
            step("sat", (c == 0) || (c == 600), 1'b1, 1'b0);
        chk("sat.period511", 32'(last_period), 32'd511);
        chk("sat.overflow",  32'(o_overflow),  32'd1);
        for (int c = 2; c < 22; c++)
            step("sat2", c == 20, 1'b1, 1'b0);
        chk("sat2.period20", 32'(last_period), 32'd20);
        chk("sat2.overflow", 32'(o_overflow),  32'd1);
        step("sat_clear", 1'b0, 1'b1, 1'b1);
        chk("sat_clear.overflow", 32'(o_overflow), 32'd0);
        chk("sat_clear.period",   32'(o_period),   32'd0);
        chk("sat_clear.busy",     32'(o_busy),     32'd0);

        // sig_in held high through reset release
        sig_in = 1'b1;
        async_reset_check("rst_high");
        for (int c = 0; c < 6; c++) step("rst_high", 1'b1, 1'b1, 1'b0);
        chk("rst_high.busy", 32'(o_busy), 32'd0);
        for (int c = 0; c < 3; c++) step("rst_high_low", 1'b0, 1'b1, 1'b0);
        step("rst_high_rise", 1'b1, 1'b1, 1'b0);
        chk("rst_high.busy_after_rise", 32'(o_busy), 32'd1);

        // async reset mid-period, then restart from IDLE
        for (int c = 0; c < 7; c++) step("mid", c == 3, 1'b1, 1'b0);
        async_reset_check("mid_rst");
        for (int c = 0; c < 16; c++) step("mid_after", (c == 2) || (c == 9), 1'b1, 1'b0);
        chk("mid_after.period", 32'(last_period), 32'd7);

        // clear coincident with a rise in MEASURE
        step("clr_rise_lo", 1'b0, 1'b1, 1'b0);
        step("clr_rise", 1'b1, 1'b1, 1'b1);
        chk("clr_rise.valid", 32'(o_valid), 32'd0);
        chk("clr_rise.busy",  32'(o_busy),  32'd0);
        for (int c = 0; c < 20; c++) step("clr_after", (c == 3) || (c == 12), 1'b1, 1'b0);
        chk("clr_after.period", 32'(last_period), 32'd9);

        // same-cycle credit: rise and enable at 0 and 3 only
        for (int c = 0; c < 3; c++) step("credit_pre", 1'b0, 1'b0, 1'b1);
        step("credit0", 1'b1, 1'b1, 1'b0);
        step("credit1", 1'b0, 1'b0, 1'b0);
        step("credit2", 1'b0, 1'b0, 1'b0);
        step("credit3", 1'b1, 1'b1, 1'b0);
        chk("credit.period", 32'(o_period), 32'd1);
        chk("credit.valid",  32'(o_valid),  32'd1);
        step("credit4", 1'b0, 1'b0, 1'b0);
        step("credit5", 1'b0, 1'b0, 1'b0);
        step("credit6", 1'b1, 1'b0, 1'b0);
        chk("credit.new_period", 32'(o_period), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bit s, e, k;
            s = ($urandom_range(0, 99) < 30);
            e = ($urandom_range(0, 99) < 70);
            k = ($urandom_range(0, 199) == 0);
            step("rand", s, e, k);
        end
        // long random-enable stretch that can saturate
        for (int c = 0; c < 1500; c++)
            step("rand_long", (c % 700) == 1, ($urandom_range(0, 3) != 0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
